// File: rtl/pcap_pkg.sv
// -----------------------------------------------------------------------------
// pcap_pkg
// Shared constants, FSM state type and a byte-select helper for the libpcap
// record framer.
//   PCAP_MAGIC / PCAP_VER_*  : fixed fields of the libpcap global header
//   GHDR_LEN / PHDR_LEN      : global header and per-record header lengths
//   pcap_state_e             : framer FSM states
//   be_byte()                : big-endian byte pick from a 32-bit word
// -----------------------------------------------------------------------------
package pcap_pkg;

   localparam logic [31:0] PCAP_MAGIC     = 32'hA1B2_C3D4;
   localparam logic [15:0] PCAP_VER_MAJOR = 16'd2;
   localparam logic [15:0] PCAP_VER_MINOR = 16'd4;
   localparam int unsigned GHDR_LEN       = 24;
   localparam int unsigned PHDR_LEN       = 16;

   typedef enum logic [2:0] {
      GHDR    = 3'd0,
      IDLE    = 3'd1,
      CAPTURE = 3'd2,
      PHDR    = 3'd3,
      PAYLOAD = 3'd4
   } pcap_state_e;

   // sel=0 returns the most significant byte (network byte order).
   function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] sel);
      logic [7:0] b;
      case (sel)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/pcap_byte_ram.sv
// -----------------------------------------------------------------------------
// pcap_byte_ram
// Simple dual-port byte RAM: synchronous write, synchronous read with one
// cycle latency. The read register only updates when re_i is high, so the
// last read value is held while the consumer is stalled.
//   clk_i            clock, rising edge
//   we_i/waddr_i/wdata_i   write port
//   re_i/raddr_i     read request
//   rdata_o          data for the address requested on the previous re_i
// -----------------------------------------------------------------------------
module pcap_byte_ram #(
   parameter int unsigned DEPTH = 2048,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [DEPTH];
   logic [7:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/pcap_record_framer.sv
// -----------------------------------------------------------------------------
// pcap_record_framer
// Converts a start/last framed byte stream into a libpcap byte stream: one
// global header after reset, then per packet a 16-byte record header and the
// (possibly truncated) payload. Packets are buffered because the lengths in
// the record header are only known once the last byte has arrived.
//   CLOCK, RESET        clock (rising edge), asynchronous active-high reset
//   in_valid/in_data/in_start/in_last, in_ready   packet input
//   out_valid/out_data, out_ready                 pcap byte output
//   pktcount            records fully emitted (wraps)
//   dropcount           packets aborted by a restart (saturates)
//   busy                high in every state except IDLE
//   dbg_state_o         current FSM state
//
// Handshake: a byte moves on a rising edge where valid & ready are both high.
// in_ready is registered and is only high in IDLE/CAPTURE. out_valid and
// out_data are registered; once out_valid is high they hold until the byte is
// taken, and a new byte is loaded on the same edge as the transfer, so the
// output runs at one byte per clock while out_ready stays high.
// -----------------------------------------------------------------------------
module pcap_record_framer
   import pcap_pkg::*;
#(
   parameter int unsigned BUF_DEPTH  = 2048,
   parameter int unsigned LINKTYPE   = 1,
   parameter int unsigned CLK_PER_US = 100
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   input  logic        in_start,
   input  logic        in_last,
   output logic        in_ready,
   output logic        out_valid,
   output logic [7:0]  out_data,
   input  logic        out_ready,
   output logic [7:0]  pktcount,
   output logic [7:0]  dropcount,
   output logic        busy,
   output pcap_state_e dbg_state_o
);

   localparam int unsigned AW         = $clog2(BUF_DEPTH);
   localparam int unsigned PW         = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_US - 1);
   localparam logic [31:0] DEPTH32    = 32'(BUF_DEPTH);
   localparam logic [31:0] LINK32     = 32'(LINKTYPE);
   localparam logic [4:0]  GHDR_END   = 5'(GHDR_LEN);
   localparam logic [4:0]  PHDR_END   = 5'(PHDR_LEN);
   localparam logic [AW-1:0] ADDR_ONE = 1;
   localparam logic [AW:0]   PCNT_ONE = 1;

   // ---------------------------------------------------------------------
   // Timestamp: prescaler -> microseconds -> seconds, free running.
   // ---------------------------------------------------------------------
   logic [PW-1:0] presc_q;
   logic [31:0]   ts_usec_q;
   logic [31:0]   ts_sec_q;

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         presc_q   <= '0;
         ts_usec_q <= '0;
         ts_sec_q  <= '0;
      end else if (presc_q == PRESC_MAX) begin
         presc_q <= '0;
         if (ts_usec_q == 32'd999_999) begin
            ts_usec_q <= '0;
            ts_sec_q  <= ts_sec_q + 32'd1;
         end else begin
            ts_usec_q <= ts_usec_q + 32'd1;
         end
      end else begin
         presc_q <= presc_q + 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Framer state
   // ---------------------------------------------------------------------
   pcap_state_e  state_q;
   logic         in_ready_q;
   logic         out_valid_q;
   logic [7:0]   out_data_q;
   logic [7:0]   pkt_q;
   logic [7:0]   drop_q;
   logic [4:0]   cnt_q;        // header byte index
   logic [31:0]  len_q;        // bytes seen in the current packet
   logic [31:0]  lat_sec_q;
   logic [31:0]  lat_usec_q;
   logic [AW:0]  pay_cnt_q;    // payload bytes already loaded into out_data_q

   // Combinational helpers
   logic         accept;
   logic         load;
   logic [31:0]  len_inc_d;
   logic [31:0]  incl_d;
   logic [AW:0]  incl_w;
   logic [31:0]  hdr_word;
   logic [7:0]   hdr_byte;
   logic         ram_we;
   logic [AW-1:0] ram_waddr;
   logic         ram_re;
   logic [AW-1:0] ram_raddr;
   logic [7:0]   ram_rdata;

   assign accept    = in_valid & in_ready_q;
   // Output register may take a new byte: empty, or its byte leaves this edge.
   assign load      = ~out_valid_q | out_ready;
   assign len_inc_d = (len_q == 32'hFFFF_FFFF) ? len_q : len_q + 32'd1;
   assign incl_d    = (len_q > DEPTH32) ? DEPTH32 : len_q;
   // incl_d never exceeds BUF_DEPTH = 2**AW, so AW+1 bits hold it exactly.
   assign incl_w    = incl_d[AW:0];

   // Header byte mux, indexed by the header byte counter.
   always_comb begin
      hdr_word = 32'h0;
      if (state_q == GHDR) begin
         case (cnt_q[4:2])
            3'd0:    hdr_word = PCAP_MAGIC;
            3'd1:    hdr_word = {PCAP_VER_MAJOR, PCAP_VER_MINOR};
            3'd4:    hdr_word = DEPTH32;
            3'd5:    hdr_word = LINK32;
            default: hdr_word = 32'h0;   // thiszone, sigfigs
         endcase
      end else begin
         case (cnt_q[3:2])
            2'd0:    hdr_word = lat_sec_q;
            2'd1:    hdr_word = lat_usec_q;
            2'd2:    hdr_word = incl_d;
            default: hdr_word = len_q;
         endcase
      end
      hdr_byte = be_byte(hdr_word, cnt_q[1:0]);
   end

   // A start byte always lands at address 0; later bytes only while they fit.
   assign ram_we    = accept & (in_start | ((state_q == CAPTURE) & (len_q < DEPTH32)));
   assign ram_waddr = in_start ? '0 : len_q[AW-1:0];

   // Read prefetch: in PAYLOAD the RAM output always holds buf[pay_cnt_q], the
   // next byte to load. PHDR keeps reading address 0 and, on the edge that
   // loads buf[0], requests address 1 so PAYLOAD starts already primed.
   always_comb begin
      ram_re    = 1'b0;
      ram_raddr = '0;
      if (state_q == PHDR) begin
         ram_re    = 1'b1;
         ram_raddr = (load && cnt_q == PHDR_END) ? ADDR_ONE : '0;
      end else if (state_q == PAYLOAD) begin
         ram_re    = load & (pay_cnt_q < incl_w);
         ram_raddr = pay_cnt_q[AW-1:0] + ADDR_ONE;
      end
   end

   pcap_byte_ram #(
      .DEPTH (BUF_DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk_i   (CLOCK),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (in_data),
      .re_i    (ram_re),
      .raddr_i (ram_raddr),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q     <= GHDR;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
         pkt_q       <= 8'h00;
         drop_q      <= 8'h00;
         cnt_q       <= '0;
         len_q       <= '0;
         lat_sec_q   <= '0;
         lat_usec_q  <= '0;
         pay_cnt_q   <= '0;
      end else begin
         case (state_q)
            GHDR: begin
               if (load) begin
                  if (cnt_q < GHDR_END) begin
                     out_data_q  <= hdr_byte;
                     out_valid_q <= 1'b1;
                     cnt_q       <= cnt_q + 5'd1;
                  end else begin
                     out_valid_q <= 1'b0;
                     in_ready_q  <= 1'b1;
                     state_q     <= IDLE;
                  end
               end
            end

            IDLE: begin
               if (accept && in_start) begin
                  lat_sec_q  <= ts_sec_q;
                  lat_usec_q <= ts_usec_q;
                  len_q      <= 32'd1;
                  if (in_last) begin
                     in_ready_q <= 1'b0;
                     cnt_q      <= '0;
                     state_q    <= PHDR;
                  end else begin
                     state_q <= CAPTURE;
                  end
               end
            end

            CAPTURE: begin
               if (accept) begin
                  if (in_start) begin
                     // Unterminated packet: abandon it and restart here.
                     if (drop_q != 8'hFF) begin
                        drop_q <= drop_q + 8'd1;
                     end
                     lat_sec_q  <= ts_sec_q;
                     lat_usec_q <= ts_usec_q;
                     len_q      <= 32'd1;
                  end else begin
                     len_q <= len_inc_d;
                  end
                  if (in_last) begin
                     in_ready_q <= 1'b0;
                     cnt_q      <= '0;
                     state_q    <= PHDR;
                  end
               end
            end

            PHDR: begin
               if (load) begin
                  if (cnt_q < PHDR_END) begin
                     out_data_q  <= hdr_byte;
                     out_valid_q <= 1'b1;
                     cnt_q       <= cnt_q + 5'd1;
                  end else begin
                     out_data_q <= ram_rdata;
                     pay_cnt_q  <= PCNT_ONE;
                     state_q    <= PAYLOAD;
                  end
               end
            end

            PAYLOAD: begin
               if (load) begin
                  if (pay_cnt_q < incl_w) begin
                     out_data_q <= ram_rdata;
                     pay_cnt_q  <= pay_cnt_q + PCNT_ONE;
                  end else begin
                     out_valid_q <= 1'b0;
                     pkt_q       <= pkt_q + 8'd1;
                     in_ready_q  <= 1'b1;
                     state_q     <= IDLE;
                  end
               end
            end

            default: state_q <= GHDR;
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign pktcount    = pkt_q;
   assign dropcount   = drop_q;
   assign busy        = (state_q != IDLE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pcap_record_framer.sv
// -----------------------------------------------------------------------------
// tb_pcap_record_framer
// Directed bench for pcap_record_framer (BUF_DEPTH=2048, LINKTYPE=1,
// CLK_PER_US=1 so ts_usec advances once per clock). Expected pcap bytes are
// queued when stimulus is issued; a negedge monitor pops and compares every
// transferred byte and checks output stability while stalled.
// -----------------------------------------------------------------------------
module tb_pcap_record_framer;
   import pcap_pkg::*;

   localparam int unsigned BUF_DEPTH  = 2048;
   localparam int unsigned LINKTYPE   = 1;
   localparam int unsigned CLK_PER_US = 1;

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b1;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_start = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready = 1'b1;
   logic [7:0]  pktcount;
   logic [7:0]  dropcount;
   logic        busy;
   pcap_state_e dbg_state;

   int n_checks = 0;
   int n_fails  = 0;

   logic [7:0] exp_q[$];
   logic       mon_en = 1'b0;
   logic       rand_rdy = 1'b0;
   logic       track_first = 1'b0;
   int unsigned first_x = 0;
   int unsigned last_x = 0;
   int unsigned cyc;

   // ---------------- clock / reset ----------------
   always #5 CLOCK = ~CLOCK;

   // Clock edges since reset release; equals ts_usec with CLK_PER_US=1.
   always @(posedge CLOCK or posedge RESET) begin
      if (RESET) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   always @(posedge CLOCK) begin
      #1;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   pcap_record_framer #(
      .BUF_DEPTH  (BUF_DEPTH),
      .LINKTYPE   (LINKTYPE),
      .CLK_PER_US (CLK_PER_US)
   ) dut (
      .CLOCK       (CLOCK),
      .RESET       (RESET),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_start    (in_start),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .pktcount    (pktcount),
      .dropcount   (dropcount),
      .busy        (busy),
      .dbg_state_o (dbg_state)
   );

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fails++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push_word(input logic [31:0] w);
      exp_q.push_back(w[31:24]);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
   endtask

   task automatic push_ghdr();
      push_word(32'hA1B2_C3D4);
      push_word(32'h0002_0004);
      push_word(32'h0000_0000);
      push_word(32'h0000_0000);
      push_word(32'h0000_0800);
      push_word(32'h0000_0001);
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_in_ready"},  32'(in_ready),  32'd0);
      check({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
      check({pfx, "_out_data"},  32'(out_data),  32'd0);
      check({pfx, "_pktcount"},  32'(pktcount),  32'd0);
      check({pfx, "_dropcount"}, 32'(dropcount), 32'd0);
      check({pfx, "_busy"},      32'(busy),      32'd1);
      check({pfx, "_state"},     32'(dbg_state), 32'(GHDR));
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = 8'h00;

   always @(negedge CLOCK) begin
      logic [7:0] e;
      if (!mon_en) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data",  32'(out_data),  32'(prev_data));
         end
         if (out_valid) check("in_ready_while_out", 32'(in_ready), 32'd0);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fails++;
               $display("FAIL unexpected_byte: got %02h, required no byte", out_data);
            end else begin
               e = exp_q.pop_front();
               check("out_byte", 32'(out_data), 32'(e));
            end
            if (track_first) first_x = cyc;
            track_first = 1'b0;
            last_x = cyc;
         end
         prev_stall = out_valid & ~out_ready;
         prev_data  = out_data;
      end
   end

   // ---------------- driver tasks ----------------
   // Sends len bytes (base+i)&FF; on a terminated packet the expected record
   // (header with bench-computed timestamp and lengths, then payload) is queued.
   task automatic send_pkt(input int len, input logic [7:0] base, input bit do_last);
      int unsigned usec = 0;
      int t;
      logic [7:0] b;
      @(posedge CLOCK); #1;
      for (int i = 0; i < len; i++) begin
         b = base + 8'(i);
         in_valid = 1'b1;
         in_data  = b;
         in_start = (i == 0);
         in_last  = do_last && (i == len - 1);
         t = 0;
         @(negedge CLOCK);
         while (!in_ready && t < 100) begin
            @(negedge CLOCK);
            t++;
         end
         if (!in_ready) begin
            n_checks++;
            n_fails++;
            $display("FAIL in_ready_timeout: got 0 at byte %0d, required 1", i);
            in_valid = 1'b0;
            return;
         end
         if (i == 0) usec = cyc;
         @(posedge CLOCK); #1;
      end
      in_valid = 1'b0;
      in_start = 1'b0;
      in_last  = 1'b0;
      if (do_last) begin
         push_word(32'h0);
         push_word(usec);
         push_word((len > int'(BUF_DEPTH)) ? BUF_DEPTH : len);
         push_word(len);
         for (int i = 0; i < len && i < int'(BUF_DEPTH); i++) begin
            b = base + 8'(i);
            exp_q.push_back(b);
         end
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      @(negedge CLOCK);
      while ((exp_q.size() != 0 || out_valid) && n < 20000) begin
         @(negedge CLOCK);
         n++;
      end
      check({name, "_drained_left"}, 32'(exp_q.size()), 32'd0);
      check({name, "_idle_out_valid"}, 32'(out_valid), 32'd0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #900000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- sequence ----------------
   initial begin
      repeat (3) @(posedge CLOCK);
      @(negedge CLOCK);
      check_reset_vals("rst");
      push_ghdr();
      mon_en = 1'b1;
      @(posedge CLOCK); #1;
      RESET = 1'b0;

      // Global header
      wait_drain("ghdr");
      check("ghdr_in_ready", 32'(in_ready), 32'd1);
      check("ghdr_busy", 32'(busy), 32'd0);

      // 60-byte packet 00..3B
      send_pkt(60, 8'h00, 1'b1);
      wait_drain("p60");
      check("p60_pktcount", 32'(pktcount), 32'd1);

      // Single-byte packet
      send_pkt(1, 8'h5A, 1'b1);
      wait_drain("p1");
      check("p1_pktcount", 32'(pktcount), 32'd2);

      // Oversized packet: truncated to the buffer, must stream without bubbles
      track_first = 1'b1;
      send_pkt(2100, 8'h07, 1'b1);
      wait_drain("p2100");
      check("p2100_span", last_x - first_x + 1, 32'd2064);
      check("p2100_pktcount", 32'(pktcount), 32'd3);

      // Random back-pressure
      rand_rdy = 1'b1;
      send_pkt(60, 8'h20, 1'b1);
      wait_drain("prand");
      rand_rdy = 1'b0;
      check("prand_pktcount", 32'(pktcount), 32'd4);

      // Restart at byte 10: first packet dropped, only the second emitted
      send_pkt(10, 8'h80, 1'b0);
      send_pkt(20, 8'h40, 1'b1);
      wait_drain("pdrop");
      check("pdrop_dropcount", 32'(dropcount), 32'd1);
      check("pdrop_pktcount", 32'(pktcount), 32'd5);

      // Reset in the middle of a payload
      mon_en = 1'b0;
      send_pkt(60, 8'h10, 1'b1);
      repeat (30) @(posedge CLOCK);
      @(negedge CLOCK);
      check("pre_reset_state", 32'(dbg_state), 32'(PAYLOAD));
      check("pre_reset_out_valid", 32'(out_valid), 32'd1);
      @(posedge CLOCK); #1;
      RESET = 1'b1;
      exp_q.delete();
      @(negedge CLOCK);
      check_reset_vals("midrst");
      push_ghdr();
      mon_en = 1'b1;
      @(posedge CLOCK); #1;
      RESET = 1'b0;
      wait_drain("ghdr2");
      check("ghdr2_in_ready", 32'(in_ready), 32'd1);

      send_pkt(3, 8'hC0, 1'b1);
      wait_drain("post");
      check("post_pktcount", 32'(pktcount), 32'd1);
      check("post_dropcount", 32'(dropcount), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
